datapath_checker: RTL and testbench

DATAPATH_CHECKER -- requirements
Module: datapath_checker

---
 rtl/datapath_checker.sv | 132 +++++++++++++
 tb/tb_datapath_checker.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_checker.sv
// Shadows a pipelined ALU: each issued op's result is predicted and compared with Y/co exactly pipe edges later.
// First-failure capture registers are built only when DATAPATH_CHECKER_CAPTURE_EN is defined.
module datapath_checker #(
  parameter int N    = 16,
  parameter int pipe = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic signed [N-1:0] A,
  input  logic signed [N-1:0] B,
  input  logic [2:0]          opcode,
  input  logic signed [N-1:0] Y,
  input  logic                co,
  input  logic                stop_on_err,
  input  logic                clear,
  output logic                mismatch,
  output logic                err_sticky,
  output logic [15:0]         pass_count,
  output logic [15:0]         fail_count,
  output logic                busy,
  output logic                halted,
  output logic [N-1:0]        cap_exp_Y,
  output logic [N-1:0]        cap_act_Y,
  output logic                cap_exp_co,
  output logic                cap_act_co
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] HALT   = 2'd2;

  logic [1:0]      state;
  logic [N:0]      sum_add;
  logic [N:0]      sum_sub;
  logic [N-1:0]    exp_y;
  logic            exp_co;
  logic [pipe-1:0] vld;
  logic [pipe-1:0] vld_nxt;
  logic [N-1:0]    sr_y  [pipe];
  logic            sr_co [pipe];
  logic            push;
  logic            cmp;
  logic            cmp_fail;

  always_comb begin
    sum_add = {1'b0, A} + {1'b0, B};
    sum_sub = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
    exp_y   = A;
    exp_co  = 1'b0;
    case (opcode)
      3'b000:  begin exp_y = sum_add[N-1:0]; exp_co = sum_add[N]; end
      3'b001:  begin exp_y = sum_sub[N-1:0]; exp_co = sum_sub[N]; end
      3'b010:  exp_y = A & B;
      3'b011:  exp_y = A | B;
      3'b100:  exp_y = A ^ B;
      3'b101:  exp_y = ~A;
      3'b110:  exp_y = {A[N-2:0], 1'b0};
      default: exp_y = A;
    endcase
  end

  // While halted, issues are dropped but in-flight entries keep draining so busy settles.
  assign push     = in_valid && (state != HALT);
  assign vld_nxt  = (vld << 1) | pipe'(push);
  assign cmp      = vld[pipe-1] && (state != HALT);
  assign cmp_fail = cmp && ((Y != sr_y[pipe-1]) || (co != sr_co[pipe-1]));

  always_ff @(posedge clk) begin
    sr_y[0]  <= exp_y;
    sr_co[0] <= exp_co;
    for (int i = 1; i < pipe; i++) begin
      sr_y[i]  <= sr_y[i-1];
      sr_co[i] <= sr_co[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state      <= IDLE;
      vld        <= '0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      pass_count <= '0;
      fail_count <= '0;
    end else begin
      vld      <= vld_nxt;
      mismatch <= cmp_fail;
      if (cmp_fail) begin
        err_sticky <= 1'b1;
        if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
      end else if (cmp && (pass_count != 16'hFFFF)) begin
        pass_count <= pass_count + 16'd1;
      end
      case (state)
        IDLE:    if (push) state <= ACTIVE;
        ACTIVE: begin
          if (cmp_fail && stop_on_err) state <= HALT;
          else if (vld_nxt == '0)      state <= IDLE;
        end
        HALT:    ;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy   = |vld;
  assign halted = (state == HALT);

`ifdef DATAPATH_CHECKER_CAPTURE_EN
  // err_sticky doubles as the "already captured" flag since both rearm only on clear/reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cap_exp_Y  <= '0;
      cap_act_Y  <= '0;
      cap_exp_co <= 1'b0;
      cap_act_co <= 1'b0;
    end else if (cmp_fail && !err_sticky) begin
      cap_exp_Y  <= sr_y[pipe-1];
      cap_act_Y  <= Y;
      cap_exp_co <= sr_co[pipe-1];
      cap_act_co <= co;
    end
  end
`else
  assign cap_exp_Y  = '0;
  assign cap_act_Y  = '0;
  assign cap_exp_co = 1'b0;
  assign cap_act_co = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_checker.sv
// Bench for datapath_checker: queue-based reference model plus directed and randomized scenarios.
module tb_datapath_checker;
  localparam int N    = 16;
  localparam int PIPE = 2;
`ifdef DATAPATH_CHECKER_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n, in_valid, co, stop_on_err, clear;
  logic signed [N-1:0] A, B, Y;
  logic [2:0]          opcode;
  logic                mismatch, err_sticky, busy, halted, cap_exp_co, cap_act_co;
  logic [15:0]         pass_count, fail_count;
  logic [N-1:0]        cap_exp_Y, cap_act_Y;

  datapath_checker #(.N(N), .pipe(PIPE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
    .Y(Y), .co(co), .stop_on_err(stop_on_err), .clear(clear),
    .mismatch(mismatch), .err_sticky(err_sticky), .pass_count(pass_count), .fail_count(fail_count),
    .busy(busy), .halted(halted), .cap_exp_Y(cap_exp_Y), .cap_act_Y(cap_act_Y),
    .cap_exp_co(cap_exp_co), .cap_act_co(cap_act_co)
  );

  always #5 clk = ~clk;

  typedef struct { logic [N-1:0] y; logic c; int due; } txn_t;
  txn_t         q[$];
  int           edge_no = 0;
  int           m_pass = 0, m_fail = 0;
  bit           m_sticky = 0, m_mis = 0, m_halt = 0, m_cec = 0, m_cac = 0;
  logic [N-1:0] m_cey = '0, m_cay = '0;
  int           n_chk = 0, n_err = 0;

  // Arithmetic statement of the ALU: sums as plain integers, carry = overflow past 2^N.
  function automatic void ref_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                 output logic [N-1:0] y, output logic c);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint m  = longint'(1) << N;
    c = 1'b0;
    case (op)
      3'd0:    begin y = N'((ua + ub) % m); c = ((ua + ub) >= m); end
      3'd1:    begin y = N'((ua - ub + m) % m); c = (ua >= ub); end
      3'd2:    y = a & b;
      3'd3:    y = a | b;
      3'd4:    y = a ^ b;
      3'd5:    y = ~a;
      3'd6:    y = N'((ua * 2) % m);
      default: y = a;
    endcase
  endfunction

  // One clock: drive inputs, present the retiring result (optionally corrupted), advance the model.
  task automatic tick(input bit iv, input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [N-1:0] fy, input bit fc, input bit clr, input bit rst);
    txn_t         t;
    logic [N-1:0] ey;
    logic         ec;
    bit           was_halt;
    if (q.size() > 0 && q[0].due == edge_no + 1) begin
      Y = q[0].y ^ fy; co = q[0].c ^ fc;
    end else begin
      Y = N'($urandom); co = 1'($urandom);
    end
    in_valid = iv; A = a; B = b; opcode = op; clear = clr; rst_n = !rst;
    ref_op(op, a, b, ey, ec);
    @(posedge clk);
    edge_no++;
    if (rst || clr) begin
      q.delete();
      m_pass = 0; m_fail = 0; m_sticky = 0; m_mis = 0; m_halt = 0;
      m_cey = '0; m_cay = '0; m_cec = 0; m_cac = 0;
    end else begin
      was_halt = m_halt;
      m_mis = 0;
      if (q.size() > 0 && q[0].due == edge_no) begin
        t = q.pop_front();
        if (!was_halt) begin
          if ((Y !== t.y) || (co !== t.c)) begin
            if (!m_sticky) begin m_cey = t.y; m_cay = Y; m_cec = t.c; m_cac = co; end
            if (m_fail < 65535) m_fail++;
            m_mis = 1; m_sticky = 1;
            if (stop_on_err) m_halt = 1;
          end else if (m_pass < 65535) begin
            m_pass++;
          end
        end
      end
      if (iv && !was_halt) q.push_back('{ey, ec, edge_no + PIPE});
    end
    #1;
  endtask

  task automatic idle();
    tick(0, 3'd0, '0, '0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    stop_on_err = 0;
    tick(0, 3'd0, '0, '0, '0, 0, 0, 1);
    tick(1, 3'd0, 16'h1234, 16'h1, '0, 0, 0, 1);
    n_chk++; if (mismatch !== 1'b0)   begin n_err++; $display("FAIL reset_mismatch got %0b want 0", mismatch); end
    n_chk++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL reset_sticky got %0b want 0", err_sticky); end
    n_chk++; if (pass_count !== 16'd0) begin n_err++; $display("FAIL reset_pass got %0d want 0", pass_count); end
    n_chk++; if (fail_count !== 16'd0) begin n_err++; $display("FAIL reset_fail got %0d want 0", fail_count); end
    n_chk++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_chk++; if (halted !== 1'b0)     begin n_err++; $display("FAIL reset_halted got %0b want 0", halted); end
    n_chk++; if ({cap_exp_Y, cap_act_Y, cap_exp_co, cap_act_co} !== '0)
      begin n_err++; $display("FAIL reset_cap got %h/%h/%b/%b want 0", cap_exp_Y, cap_act_Y, cap_exp_co, cap_act_co); end
  endtask

  task automatic test_add_pass();
    tick(0, 3'd0, '0, '0, '0, 0, 1, 0);
    tick(1, 3'd0, 16'h7FFF, 16'h0001, '0, 0, 0, 0);
    n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL add_busy got %0b want 1", busy); end
    idle();
    n_chk++; if (pass_count !== 16'd0) begin n_err++; $display("FAIL add_early_pass got %0d want 0", pass_count); end
    idle();
    n_chk++; if (pass_count !== 16'd1) begin n_err++; $display("FAIL add_pass got %0d want 1", pass_count); end
    n_chk++; if (mismatch !== 1'b0)    begin n_err++; $display("FAIL add_mismatch got %0b want 0", mismatch); end
    n_chk++; if (fail_count !== 16'd0) begin n_err++; $display("FAIL add_fail got %0d want 0", fail_count); end
  endtask

  task automatic test_add_fail();
    tick(0, 3'd0, '0, '0, '0, 0, 1, 0);
    tick(1, 3'd0, 16'hFFFF, 16'h0001, '0, 0, 0, 0);
    idle();
    tick(0, 3'd0, '0, '0, '0, 1, 0, 0);  // Y=0 correct, co dropped to 0
    n_chk++; if (fail_count !== 16'd1) begin n_err++; $display("FAIL carry_fail got %0d want 1", fail_count); end
    n_chk++; if (pass_count !== 16'd0) begin n_err++; $display("FAIL carry_pass got %0d want 0", pass_count); end
    n_chk++; if (mismatch !== 1'b1)    begin n_err++; $display("FAIL carry_pulse got %0b want 1", mismatch); end
    n_chk++; if (err_sticky !== 1'b1)  begin n_err++; $display("FAIL carry_sticky got %0b want 1", err_sticky); end
    n_chk++; if (cap_exp_co !== CAP)   begin n_err++; $display("FAIL cap_exp_co got %0b want %0b", cap_exp_co, CAP); end
    n_chk++; if (cap_act_co !== 1'b0)  begin n_err++; $display("FAIL cap_act_co got %0b want 0", cap_act_co); end
    idle();
    n_chk++; if (mismatch !== 1'b0)    begin n_err++; $display("FAIL carry_pulse_end got %0b want 0", mismatch); end
    n_chk++; if (err_sticky !== 1'b1)  begin n_err++; $display("FAIL carry_sticky_hold got %0b want 1", err_sticky); end
  endtask

  task automatic test_back_to_back();
    tick(0, 3'd0, '0, '0, '0, 0, 1, 0);
    tick(1, 3'd1, 16'd5, 16'd7, '0, 0, 0, 0);
    tick(1, 3'd4, 16'h00FF, 16'h0F0F, '0, 0, 0, 0);
    tick(1, 3'd6, 16'h4001, 16'h0000, '0, 0, 0, 0);
    n_chk++; if (pass_count !== 16'd1) begin n_err++; $display("FAIL b2b_pass1 got %0d want 1", pass_count); end
    idle();
    n_chk++; if (pass_count !== 16'd2) begin n_err++; $display("FAIL b2b_pass2 got %0d want 2", pass_count); end
    n_chk++; if (busy !== 1'b1)        begin n_err++; $display("FAIL b2b_busy got %0b want 1", busy); end
    idle();
    n_chk++; if (pass_count !== 16'd3) begin n_err++; $display("FAIL b2b_pass3 got %0d want 3", pass_count); end
    n_chk++; if (fail_count !== 16'd0) begin n_err++; $display("FAIL b2b_fail got %0d want 0", fail_count); end
    n_chk++; if (busy !== 1'b0)        begin n_err++; $display("FAIL b2b_busy_end got %0b want 0", busy); end
  endtask

  task automatic test_stop_on_err();
    tick(0, 3'd0, '0, '0, '0, 0, 1, 0);
    stop_on_err = 1;
    tick(1, 3'd0, 16'd1, 16'd2, '0, 0, 0, 0);
    tick(1, 3'd3, 16'd3, 16'd4, '0, 0, 0, 0);
    tick(1, 3'd2, 16'd6, 16'd3, 16'h0010, 0, 0, 0);
    n_chk++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_enter got %0b want 1", halted); end
    idle(); idle();
    tick(1, 3'd7, 16'h0055, 16'h0000, '0, 0, 0, 0);
    idle(); idle(); idle();
    n_chk++; if (halted !== 1'b1)      begin n_err++; $display("FAIL halt_hold got %0b want 1", halted); end
    n_chk++; if (fail_count !== 16'd1) begin n_err++; $display("FAIL halt_fail got %0d want 1", fail_count); end
    n_chk++; if (pass_count !== 16'd0) begin n_err++; $display("FAIL halt_pass got %0d want 0", pass_count); end
    n_chk++; if (busy !== 1'b0)        begin n_err++; $display("FAIL halt_busy got %0b want 0", busy); end
    tick(0, 3'd0, '0, '0, '0, 0, 1, 0);
    n_chk++; if (halted !== 1'b0)     begin n_err++; $display("FAIL clear_halted got %0b want 0", halted); end
    n_chk++; if ({pass_count, fail_count} !== 32'd0)
      begin n_err++; $display("FAIL clear_counts got %0d/%0d want 0/0", pass_count, fail_count); end
    n_chk++; if (err_sticky !== 1'b0) begin n_err++; $display("FAIL clear_sticky got %0b want 0", err_sticky); end
    stop_on_err = 0;
  endtask

  task automatic test_reset_midflight();
    tick(0, 3'd0, '0, '0, '0, 0, 1, 0);
    tick(1, 3'd0, 16'd1, 16'd1, '0, 0, 0, 0);
    tick(1, 3'd1, 16'd9, 16'd2, '0, 0, 0, 0);
    tick(0, 3'd0, '0, '0, '0, 0, 0, 1);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got %0b want 0", busy); end
    idle();
    n_chk++; if ({pass_count, fail_count} !== 32'd0)
      begin n_err++; $display("FAIL rstmid_counts got %0d/%0d want 0/0", pass_count, fail_count); end
    tick(1, 3'd4, 16'd1, 16'd3, '0, 0, 0, 0);
    idle();
    n_chk++; if (pass_count !== 16'd0) begin n_err++; $display("FAIL rstmid_early got %0d want 0", pass_count); end
    idle();
    n_chk++; if (pass_count !== 16'd1) begin n_err++; $display("FAIL rstmid_first got %0d want 1", pass_count); end
  endtask

  task automatic test_clear_with_valid();
    tick(0, 3'd0, '0, '0, '0, 0, 1, 0);
    tick(1, 3'd0, 16'd1, 16'd2, '0, 0, 1, 0);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL clrvld_busy got %0b want 0", busy); end
    idle(); idle(); idle();
    n_chk++; if ({pass_count, fail_count} !== 32'd0)
      begin n_err++; $display("FAIL clrvld_counts got %0d/%0d want 0/0", pass_count, fail_count); end
  endtask

  function automatic logic [N-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(N-1){1'b1}}};
      3:       return {1'b1, {(N-1){1'b0}}};
      default: return N'($urandom);
    endcase
  endfunction

  task automatic test_random();
    tick(0, 3'd0, '0, '0, '0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] fy;
      fy = ($urandom_range(0, 7) == 0) ? N'(1 << $urandom_range(0, N-1)) : '0;
      stop_on_err = ($urandom_range(0, 3) == 0);
      tick($urandom_range(0, 3) != 0, 3'($urandom), pick_operand(), pick_operand(), fy,
           $urandom_range(0, 11) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
      n_chk++; if (pass_count !== 16'(m_pass)) begin n_err++; $display("FAIL rnd_pass cyc %0d got %0d want %0d", i, pass_count, m_pass); end
      n_chk++; if (fail_count !== 16'(m_fail)) begin n_err++; $display("FAIL rnd_fail cyc %0d got %0d want %0d", i, fail_count, m_fail); end
      n_chk++; if (mismatch !== m_mis)     begin n_err++; $display("FAIL rnd_mismatch cyc %0d got %0b want %0b", i, mismatch, m_mis); end
      n_chk++; if (err_sticky !== m_sticky) begin n_err++; $display("FAIL rnd_sticky cyc %0d got %0b want %0b", i, err_sticky, m_sticky); end
      n_chk++; if (busy !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_busy cyc %0d got %0b want %0b", i, busy, q.size() > 0); end
      n_chk++; if (halted !== m_halt)      begin n_err++; $display("FAIL rnd_halted cyc %0d got %0b want %0b", i, halted, m_halt); end
      n_chk++; if ({cap_exp_Y, cap_act_Y, cap_exp_co, cap_act_co} !== (CAP ? {m_cey, m_cay, m_cec, m_cac} : '0))
        begin n_err++; $display("FAIL rnd_cap cyc %0d got %h/%h/%b/%b want %h/%h/%b/%b", i, cap_exp_Y, cap_act_Y,
                                cap_exp_co, cap_act_co, m_cey, m_cay, m_cec, m_cac); end
    end
    stop_on_err = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; A = '0; B = '0; opcode = '0; Y = '0; co = 0; stop_on_err = 0; clear = 0;
    #2;
    test_reset();
    test_add_pass();
    test_add_fail();
    test_back_to_back();
    test_stop_on_err();
    test_reset_midflight();
    test_clear_with_valid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
